// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the IF/LS memory arbiter.
//   arb_state_t  - arbiter FSM states
//   owner_t      - which requester owns the in-flight transaction
//   IF_BE_ALL    - byte enables driven for instruction fetches
//   TIMEOUT_DATA - read data returned on a timed-out transaction
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_LS
  } owner_t;

  localparam logic [3:0]  IF_BE_ALL    = 4'hF;
  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, load/store and memory-side signals of
// mem_arbiter.
//   slave  - arbiter view (requests/memory responses in, grants/bus out)
//   master - environment view (requesters and memory)
// With MEM_TIMEOUT_EN defined, per-requester error pulses if_err_o/ls_err_o
// are added.
interface mem_arbiter_if #(
  parameter int unsigned BITSIZE = 32
);

  logic               if_req_i;
  logic [BITSIZE-1:0] if_addr_i;
  logic               if_gnt_o;
  logic [31:0]        if_rdata_o;
  logic               if_valid_o;

  logic               ls_req_i;
  logic               ls_we_i;
  logic [3:0]         ls_be_i;
  logic [BITSIZE-1:0] ls_addr_i;
  logic [31:0]        ls_wdata_i;
  logic               ls_gnt_o;
  logic [31:0]        ls_rdata_o;
  logic               ls_valid_o;

  logic               mem_req_o;
  logic               mem_we_o;
  logic [3:0]         mem_be_o;
  logic [BITSIZE-1:0] mem_addr_o;
  logic [31:0]        mem_wdata_o;
  logic               mem_gnt_i;
  logic               mem_rvalid_i;
  logic [31:0]        mem_rdata_i;

  logic               busy_o;

`ifdef MEM_TIMEOUT_EN
  logic               if_err_o;
  logic               ls_err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rdata_o, if_valid_o, if_err_o,
    output ls_gnt_o, ls_rdata_o, ls_valid_o, ls_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rdata_o, if_valid_o, if_err_o,
    input  ls_gnt_o, ls_rdata_o, ls_valid_o, ls_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  busy_o
  );
`else
  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rdata_o, if_valid_o,
    output ls_gnt_o, ls_rdata_o, ls_valid_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rdata_o, if_valid_o,
    input  ls_gnt_o, ls_rdata_o, ls_valid_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  busy_o
  );
`endif

endinterface

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter_2: combinational two-way round-robin pick.
//   req_if, req_ls - requests from fetch and load/store
//   last_winner    - owner of the most recently completed transaction
//   gnt            - one-hot grant, bit 0 = IF, bit 1 = LS (zero if no request)
//   winner         - selected owner (OWNER_IF when nobody requests)
module rr_arbiter_2
  import mem_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_ls,
  input  owner_t     last_winner,
  output logic [1:0] gnt,
  output owner_t     winner
);

  always_comb begin
    winner = OWNER_IF;
    if (req_if && req_ls) begin
      // On a tie the requester that did not win last time goes first.
      winner = (last_winner == OWNER_IF) ? OWNER_LS : OWNER_IF;
    end else if (req_ls) begin
      winner = OWNER_LS;
    end
    gnt    = '0;
    gnt[0] = req_if && (winner == OWNER_IF);
    gnt[1] = req_ls && (winner == OWNER_LS);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch (IF)
// and load/store (LS). Round-robin arbitration, one transaction in flight.
//   clk      - rising-edge clock
//   resetn_i - synchronous active-low reset
//   bus      - mem_arbiter_if.slave: IF/LS request ports, memory bus, busy_o
// Optional: MEM_TIMEOUT_EN adds a REQ/WAIT timeout (TIMEOUT_CYCLES) that
// completes the transaction with zero data and pulses if_err_o/ls_err_o.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned BITSIZE        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          resetn_i,
  mem_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t         state_q;
  owner_t             owner_q;
  owner_t             last_winner_q;
  logic [BITSIZE-1:0] addr_q;
  logic               we_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [31:0]        if_rdata_q;
  logic [31:0]        ls_rdata_q;

  logic [1:0]         pick_gnt;
  owner_t             pick_winner;
  logic               done;
  logic               abort;
  logic [31:0]        resp_data;

  rr_arbiter_2 u_rr (
    .req_if      (bus.if_req_i),
    .req_ls      (bus.ls_req_i),
    .last_winner (last_winner_q),
    .gnt         (pick_gnt),
    .winner      (pick_winner)
  );

  // rvalid only counts in WAIT, or in REQ together with gnt; anything else is
  // a stale response and is ignored.
  assign done = ((state_q == REQ) && bus.mem_gnt_i && bus.mem_rvalid_i) ||
                ((state_q == WAIT) && bus.mem_rvalid_i);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  assign abort = ((state_q == REQ) || (state_q == WAIT)) && !done &&
                 (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  assign resp_data = abort ? TIMEOUT_DATA : bus.mem_rdata_i;

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_IF;
      last_winner_q <= OWNER_IF;
      addr_q        <= '0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      if_rdata_q    <= '0;
      ls_rdata_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      // Each requester keeps its own rdata register so the non-owner's
      // output holds its last value.
      if (done || abort) begin
        if (owner_q == OWNER_IF) begin
          if_rdata_q <= resp_data;
        end else begin
          ls_rdata_q <= resp_data;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (|pick_gnt) begin
            owner_q <= pick_winner;
            state_q <= REQ;
            if (pick_winner == OWNER_LS) begin
              addr_q  <= bus.ls_addr_i;
              we_q    <= bus.ls_we_i;
              be_q    <= bus.ls_be_i;
              wdata_q <= bus.ls_wdata_i;
            end else begin
              addr_q  <= bus.if_addr_i;
              we_q    <= 1'b0;
              be_q    <= IF_BE_ALL;
              wdata_q <= '0;
            end
          end
        end
        REQ: begin
          if (done || abort) begin
            state_q <= RESP;
          end else if (bus.mem_gnt_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (done || abort) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          last_winner_q <= owner_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

`ifdef MEM_TIMEOUT_EN
      // Clearing in IDLE means the counter reads 0 on the first REQ cycle.
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if ((state_q == REQ) || (state_q == WAIT)) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (done || abort) begin
        err_q <= abort;
      end
`endif
    end
  end

  assign bus.if_gnt_o    = resetn_i && (state_q == IDLE) && pick_gnt[0];
  assign bus.ls_gnt_o    = resetn_i && (state_q == IDLE) && pick_gnt[1];
  assign bus.if_valid_o  = (state_q == RESP) && (owner_q == OWNER_IF);
  assign bus.ls_valid_o  = (state_q == RESP) && (owner_q == OWNER_LS);
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rdata_o  = ls_rdata_q;

  assign bus.mem_req_o   = (state_q == REQ);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_be_o    = be_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

  assign bus.busy_o      = (state_q != IDLE);

`ifdef MEM_TIMEOUT_EN
  assign bus.if_err_o    = bus.if_valid_o && err_q;
  assign bus.ls_err_o    = bus.ls_valid_o && err_q;
`endif

endmodule
